// File: rtl/fetch_unit.sv
// Fetch stage for the 4-bit CPU: owns the PC and captures one- or two-byte
// instructions into a fetch register handed to decode over valid/ready.
module fetch_unit #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [7:0] HLT_OPCODE = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pc_out,
    input  logic [7:0] instr_in,
    input  logic [7:0] next_byte_in,
    input  logic       branch_valid,
    input  logic [7:0] branch_target,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [7:0] ir_opcode,
    output logic [7:0] ir_operand,
    output logic       ir_two_byte,
    output logic [7:0] ir_pc,
    output logic       halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    logic       ir_valid_reg, ir_valid_next;
    logic [7:0] ir_opcode_reg, ir_opcode_next;
    logic [7:0] ir_operand_reg, ir_operand_next;
    logic       ir_two_byte_reg, ir_two_byte_next;
    logic [7:0] ir_pc_reg, ir_pc_next;
    logic       halted_reg, halted_next;

    logic       two_byte;
    logic       load;

    assign two_byte = (instr_in[7:6] == 2'b10);

    // A slot is free when the IR is empty or being consumed; a redirect
    // always wins so nothing is fetched from the stale PC.
    assign load = (state_reg == RUN) && !branch_valid &&
                  (!ir_valid_reg || ir_ready);

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        ir_valid_next    = ir_valid_reg;
        ir_opcode_next   = ir_opcode_reg;
        ir_operand_next  = ir_operand_reg;
        ir_two_byte_next = ir_two_byte_reg;
        ir_pc_next       = ir_pc_reg;
        halted_next      = halted_reg;

        if (branch_valid) begin
            pc_next       = branch_target;
            ir_valid_next = 1'b0;
            state_next    = RUN;
            halted_next   = 1'b0;
        end else if (load) begin
            ir_opcode_next   = instr_in;
            ir_operand_next  = two_byte ? next_byte_in : 8'h00;
            ir_two_byte_next = two_byte;
            ir_pc_next       = pc_reg;
            ir_valid_next    = 1'b1;
            pc_next          = pc_reg + (two_byte ? 8'd2 : 8'd1);
            if (instr_in == HLT_OPCODE) begin
                state_next  = HALT;
                halted_next = 1'b1;
            end
        end else if (ir_valid_reg && ir_ready) begin
            ir_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            ir_valid_reg    <= 1'b0;
            ir_opcode_reg   <= 8'h00;
            ir_operand_reg  <= 8'h00;
            ir_two_byte_reg <= 1'b0;
            ir_pc_reg       <= 8'h00;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            ir_valid_reg    <= ir_valid_next;
            ir_opcode_reg   <= ir_opcode_next;
            ir_operand_reg  <= ir_operand_next;
            ir_two_byte_reg <= ir_two_byte_next;
            ir_pc_reg       <= ir_pc_next;
            halted_reg      <= halted_next;
        end
    end

    assign pc_out      = pc_reg;
    assign ir_valid    = ir_valid_reg;
    assign ir_opcode   = ir_opcode_reg;
    assign ir_operand  = ir_operand_reg;
    assign ir_two_byte = ir_two_byte_reg;
    assign ir_pc       = ir_pc_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions queued by stimulus,
// popped by a monitor on each accepted handshake; direct checks for PC/state.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] pc_out;
    logic [7:0] instr_in;
    logic [7:0] next_byte_in;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_opcode;
    logic [7:0] ir_operand;
    logic       ir_two_byte;
    logic [7:0] ir_pc;
    logic       halted;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] opnd;
        logic       two;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.RESET_PC(8'h00), .HLT_OPCODE(8'hF0)) dut (
        .clk(clk),
        .rst(rst),
        .pc_out(pc_out),
        .instr_in(instr_in),
        .next_byte_in(next_byte_in),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .ir_opcode(ir_opcode),
        .ir_operand(ir_operand),
        .ir_two_byte(ir_two_byte),
        .ir_pc(ir_pc),
        .halted(halted)
    );

    assign instr_in     = mem[pc_out];
    assign next_byte_in = (pc_out == 8'hFF) ? 8'h00 : mem[pc_out + 8'd1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] opnd,
                        input logic two, input logic [7:0] pc);
        exp_t e;
        e.op = op; e.opnd = opnd; e.two = two; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset();
        chk("rst_pc_out", pc_out, 8'h00);
        chk("rst_ir_valid", {7'd0, ir_valid}, 8'h00);
        chk("rst_opcode", ir_opcode, 8'h00);
        chk("rst_operand", ir_operand, 8'h00);
        chk("rst_two_byte", {7'd0, ir_two_byte}, 8'h00);
        chk("rst_ir_pc", ir_pc, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);
    endtask

    // Monitor: every accepted (non-discarded) instruction must match the queue head.
    always @(negedge clk) begin
        if (!rst && ir_valid && ir_ready && !branch_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got op %02h pc %02h expected none", ir_opcode, ir_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc_opcode", ir_opcode, e.op);
                chk("acc_operand", ir_operand, e.opnd);
                chk("acc_two_byte", {7'd0, ir_two_byte}, {7'd0, e.two});
                chk("acc_ir_pc", ir_pc, e.pc);
                $display("accept op=%02h opnd=%02h two=%0d pc=%02h", ir_opcode, ir_operand, ir_two_byte, ir_pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h82; mem[8'h02] = 8'h3C;
        mem[8'h03] = 8'h05; mem[8'h04] = 8'h21; mem[8'h05] = 8'hF0;
        mem[8'h40] = 8'h33; mem[8'h41] = 8'h8B; mem[8'h42] = 8'h55;
        mem[8'hFF] = 8'h9A;

        rst = 1'b1; ir_ready = 1'b1; branch_valid = 1'b0; branch_target = 8'h00;
        step(); step();
        chk_reset();

        // Sequential fetch: 01, 82 3C, 05, 21, HLT
        push(8'h01, 8'h00, 1'b0, 8'h00);
        push(8'h82, 8'h3C, 1'b1, 8'h01);
        push(8'h05, 8'h00, 1'b0, 8'h03);
        push(8'h21, 8'h00, 1'b0, 8'h04);
        push(8'hF0, 8'h00, 1'b0, 8'h05);
        rst = 1'b0;
        step(); chk("seq_pc1", pc_out, 8'h01); chk("seq_valid1", {7'd0, ir_valid}, 8'h01);
        step(); chk("seq_pc2", pc_out, 8'h03);
        step(); chk("seq_pc3", pc_out, 8'h04);
        step(); chk("seq_pc4", pc_out, 8'h05);
        step(); chk("hlt_halted", {7'd0, halted}, 8'h01); chk("hlt_pc", pc_out, 8'h06);
        step(); chk("hlt_drain", {7'd0, ir_valid}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_pc_hold", pc_out, 8'h06);
            chk("halt_no_valid", {7'd0, ir_valid}, 8'h00);
        end

        // Branch out of HALT back to 00
        branch_valid = 1'b1; branch_target = 8'h00;
        step();
        branch_valid = 1'b0;
        chk("br0_valid", {7'd0, ir_valid}, 8'h00);
        chk("br0_pc", pc_out, 8'h00);
        chk("br0_halted", {7'd0, halted}, 8'h00);
        push(8'h01, 8'h00, 1'b0, 8'h00);
        push(8'h82, 8'h3C, 1'b1, 8'h01);
        step(); chk("resume_ir_pc", ir_pc, 8'h00);
        step(); chk("resume_pc", pc_out, 8'h03);

        // Stall with 82 captured
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_opcode", ir_opcode, 8'h82);
            chk("stall_operand", ir_operand, 8'h3C);
            chk("stall_ir_pc", ir_pc, 8'h01);
            chk("stall_pc_out", pc_out, 8'h03);
            chk("stall_valid", {7'd0, ir_valid}, 8'h01);
        end
        ir_ready = 1'b1;
        step();
        chk("release_opcode", ir_opcode, 8'h05);
        chk("release_ir_pc", ir_pc, 8'h03);

        // Branch to 40 while valid && ready: 05 is discarded
        branch_valid = 1'b1; branch_target = 8'h40;
        step();
        branch_valid = 1'b0;
        chk("br40_valid", {7'd0, ir_valid}, 8'h00);
        chk("br40_pc", pc_out, 8'h40);
        step();
        chk("br40_ir_pc", ir_pc, 8'h40);
        chk("br40_opcode", ir_opcode, 8'h33);

        // Wrap: two-byte at FF
        branch_valid = 1'b1; branch_target = 8'hFF;
        step();
        branch_valid = 1'b0;
        chk("brFF_pc", pc_out, 8'hFF);
        push(8'h9A, 8'h00, 1'b1, 8'hFF);
        step();
        chk("wrap2_two_byte", {7'd0, ir_two_byte}, 8'h01);
        chk("wrap2_operand", ir_operand, 8'h00);
        chk("wrap2_pc", pc_out, 8'h01);
        step();

        // Wrap: one-byte at FF
        mem[8'hFF] = 8'h11;
        branch_valid = 1'b1; branch_target = 8'hFF;
        step();
        branch_valid = 1'b0;
        push(8'h11, 8'h00, 1'b0, 8'hFF);
        step();
        chk("wrap1_pc", pc_out, 8'h00);
        chk("wrap1_ir_pc", ir_pc, 8'hFF);
        step();

        // Reset during stall
        ir_ready = 1'b0;
        step();
        chk("pre_rst_stall_op", ir_opcode, 8'h01);
        rst = 1'b1;
        step();
        chk_reset();
        rst = 1'b0;
        step();

        // Reset during HALT
        ir_ready = 1'b1;
        branch_valid = 1'b1; branch_target = 8'h05;
        step();
        branch_valid = 1'b0;
        push(8'hF0, 8'h00, 1'b0, 8'h05);
        step(); chk("halt2_halted", {7'd0, halted}, 8'h01);
        step(); chk("halt2_drain", {7'd0, ir_valid}, 8'h00);
        rst = 1'b1;
        step();
        chk_reset();
        rst = 1'b0;
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
